// File: rtl/uart_msg_streamer.sv
// Byte-serial message source: fixed text, optional live hex value and CR/LF,
// sent one-shot on start or free-running with an idle gap between messages.
module uart_msg_streamer #(
    parameter int                     MSG_LEN    = 5,
    parameter logic [8*MSG_LEN-1:0]   MSG        = "Hello",
    parameter int                     HEX_DIGITS = 0,
    parameter int                     ADD_CRLF   = 1,
    parameter int                     GAP_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        repeat_en,
    input  logic [31:0] value,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done,
    output logic [15:0] msg_count
);

    localparam int L     = MSG_LEN + HEX_DIGITS + 2 * ADD_CRLF;
    localparam int IDX_W = (L > 1) ? $clog2(L) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(L - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t            state_q, state_n;
    logic [IDX_W-1:0]  idx_q, idx_n, idx_inc;
    logic [GAP_W-1:0]  gap_q, gap_n;
    logic [31:0]       value_q, value_n;
    logic              valid_n, done_n;
    logic [7:0]        data_n;
    logic [15:0]       count_n;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Text first (MSB byte = first character), then hex nibbles MSN first, then CR, LF.
    function automatic logic [7:0] msg_byte(input logic [IDX_W-1:0] i, input logic [31:0] v);
        int         ii;
        int         nib_pos;
        logic [3:0] nib;
        ii = int'(i);
        if (ii < MSG_LEN)
            return MSG[8*(MSG_LEN-1-ii) +: 8];
        if (ii < MSG_LEN + HEX_DIGITS) begin
            nib_pos = HEX_DIGITS - 1 - (ii - MSG_LEN);
            nib     = 4'(v >> (4 * nib_pos));
            return hex_ascii(nib);
        end
        if (ii == MSG_LEN + HEX_DIGITS)
            return 8'h0D;
        return 8'h0A;
    endfunction

    assign idx_inc = idx_q + 1'b1;

    always_comb begin
        state_n = state_q;
        idx_n   = idx_q;
        gap_n   = gap_q;
        value_n = value_q;
        valid_n = tx_valid;
        data_n  = tx_data;
        done_n  = 1'b0;
        count_n = msg_count;
        case (state_q)
            IDLE: begin
                valid_n = 1'b0;
                if (start || repeat_en) begin
                    state_n = SEND;
                    value_n = value;
                    idx_n   = '0;
                    valid_n = 1'b1;
                    data_n  = msg_byte('0, value);
                end
            end
            SEND: begin
                if (tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        done_n  = 1'b1;
                        count_n = msg_count + 16'd1;
                        valid_n = 1'b0;
                        gap_n   = '0;
                        state_n = repeat_en ? GAP : IDLE;
                    end else begin
                        idx_n  = idx_inc;
                        data_n = msg_byte(idx_inc, value_q);
                    end
                end
            end
            GAP: begin
                valid_n = 1'b0;
                if (gap_q == GAP_LAST) begin
                    if (repeat_en) begin
                        state_n = SEND;
                        value_n = value;
                        idx_n   = '0;
                        valid_n = 1'b1;
                        data_n  = msg_byte('0, value);
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    gap_n = gap_q + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            gap_q     <= '0;
            value_q   <= '0;
            tx_valid  <= 1'b0;
            tx_data   <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
            msg_count <= 16'd0;
        end else begin
            state_q   <= state_n;
            idx_q     <= idx_n;
            gap_q     <= gap_n;
            value_q   <= value_n;
            tx_valid  <= valid_n;
            tx_data   <= data_n;
            busy      <= (state_n != IDLE);
            done      <= done_n;
            msg_count <= count_n;
        end
    end

endmodule

// File: tb/tb_uart_msg_streamer.sv
// Directed bench for uart_msg_streamer: one instance with default text and a
// short gap, one with a 4-digit hex field.
module tb_uart_msg_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, repeat0, ready0;
    logic [31:0] value0;
    logic        valid0, busy0, done0;
    logic [7:0]  data0;
    logic [15:0] count0;
    logic        start1, repeat1, ready1;
    logic [31:0] value1;
    logic        valid1, busy1, done1;
    logic [7:0]  data1;
    logic [15:0] count1;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp0 [7]  = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0D, 8'h0A};
    logic [7:0] exp1 [11] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F,
                              8'h31, 8'h41, 8'h32, 8'h46, 8'h0D, 8'h0A};

    always #5 clk = ~clk;

    uart_msg_streamer #(.GAP_CYCLES(10)) u0 (
        .clk(clk), .rst(rst), .start(start0), .repeat_en(repeat0), .value(value0),
        .tx_valid(valid0), .tx_data(data0), .tx_ready(ready0),
        .busy(busy0), .done(done0), .msg_count(count0)
    );

    uart_msg_streamer #(.HEX_DIGITS(4)) u1 (
        .clk(clk), .rst(rst), .start(start1), .repeat_en(repeat1), .value(value1),
        .tx_valid(valid1), .tx_data(data1), .tx_ready(ready1),
        .busy(busy1), .done(done1), .msg_count(count1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expects u0 to present its 7 bytes back-to-back with ready held high.
    task automatic run_msg0(input string tag, input int drop_at);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("%s_vld%0d", tag, i), {31'd0, valid0}, 32'd1);
            chk($sformatf("%s_dat%0d", tag, i), {24'd0, data0}, {24'd0, exp0[i]});
            if (i == drop_at) repeat0 = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, dones, lows, viol;
        rst = 1'b1;
        start0 = 0; repeat0 = 0; ready0 = 0; value0 = 0;
        start1 = 0; repeat1 = 0; ready1 = 0; value1 = 0;
        repeat (3) @(negedge clk);
        chk("rst_vld",   {31'd0, valid0}, 32'd0);
        chk("rst_dat",   {24'd0, data0},  32'd0);
        chk("rst_busy",  {31'd0, busy0},  32'd0);
        chk("rst_done",  {31'd0, done0},  32'd0);
        chk("rst_count", {16'd0, count0}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // One-shot, ready always high
        ready0 = 1'b1;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk("os_busy", {31'd0, busy0}, 32'd1);
        run_msg0("os", -1);
        chk("os_done",  {31'd0, done0},  32'd1);
        chk("os_vld",   {31'd0, valid0}, 32'd0);
        chk("os_busy0", {31'd0, busy0},  32'd0);
        chk("os_count", {16'd0, count0}, 32'd1);
        @(negedge clk);
        chk("os_done0", {31'd0, done0},  32'd0);

        // Backpressure 0,0,1,0,1,... with start re-pulsed during SEND
        ready0 = 1'b0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        k = 0; dones = 0;
        for (int c = 0; c < 40 && k < 7; c++) begin
            chk($sformatf("bp_vld%0d", c), {31'd0, valid0}, 32'd1);
            chk($sformatf("bp_dat%0d", c), {24'd0, data0}, {24'd0, exp0[k]});
            if (done0) dones++;
            ready0 = (c >= 2) && (((c - 2) % 2) == 0);
            start0 = (c == 3);
            @(negedge clk);
            if (ready0) k++;
        end
        start0 = 1'b0;
        ready0 = 1'b1;
        chk("bp_bytes", k, 32'd7);
        chk("bp_early_done", dones, 32'd0);
        chk("bp_done",  {31'd0, done0},  32'd1);
        chk("bp_vld",   {31'd0, valid0}, 32'd0);
        chk("bp_count", {16'd0, count0}, 32'd2);
        @(negedge clk);
        chk("bp_done0", {31'd0, done0},  32'd0);

        // Hex field; value changes after start must not leak in
        ready1 = 1'b1;
        value1 = 32'h0000_1A2F;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        value1 = 32'h0000_FFFF;
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("hx_vld%0d", i), {31'd0, valid1}, 32'd1);
            chk($sformatf("hx_dat%0d", i), {24'd0, data1}, {24'd0, exp1[i]});
            @(negedge clk);
        end
        chk("hx_done",  {31'd0, done1},  32'd1);
        chk("hx_count", {16'd0, count1}, 32'd1);

        // Repeat mode with a 10-cycle gap, start pulsed inside the gap
        repeat0 = 1'b1;
        @(negedge clk);
        run_msg0("rp1", -1);
        chk("rp1_done", {31'd0, done0}, 32'd1);
        chk("rp1_busy", {31'd0, busy0}, 32'd1);
        lows = 0;
        while (!valid0 && lows < 50) begin
            lows++;
            start0 = (lows == 3);
            @(negedge clk);
        end
        start0 = 1'b0;
        chk("rp_gap_len", lows, 32'd10);
        run_msg0("rp2", 3);
        chk("rp2_done",  {31'd0, done0},  32'd1);
        chk("rp2_busy",  {31'd0, busy0},  32'd0);
        chk("rp2_count", {16'd0, count0}, 32'd4);
        viol = 0;
        repeat (15) begin
            @(negedge clk);
            if (valid0 || busy0) viol++;
        end
        chk("rp_stop", viol, 32'd0);

        // Reset while byte 3 is presented
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (3) @(negedge clk);
        chk("mr_dat3", {24'd0, data0}, 32'h6C);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mr_vld",   {31'd0, valid0}, 32'd0);
        chk("mr_count", {16'd0, count0}, 32'd0);
        chk("mr_busy",  {31'd0, busy0},  32'd0);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        run_msg0("mr", -1);
        chk("mr_done",   {31'd0, done0},  32'd1);
        chk("mr_count1", {16'd0, count0}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_msg_streamer.md
# uart_msg_streamer

Parametrised UART message source: emits a fixed ASCII string, optionally followed by a live hexadecimal value and CR/LF, one byte at a time into the UART transmitter over a valid/ready handshake. Supports one-shot transmission on a start pulse and free-running repeat with a programmable inter-message gap. It sits between status/debug logic and `uart_tx`, and replaces the fixed-text boot greeter as the general telemetry/banner source.

## Interface
- `MSG_LEN`, 5: number of fixed text bytes, ≥1.
- `MSG`, "Hello": 8*MSG_LEN-bit string; the first character is in the most significant byte.
- `HEX_DIGITS`, 0: number of hex digits of `value` appended after the text, 0..8, taken from the low nibbles.
- `ADD_CRLF`, 1: 1 appends 8'h0D, 8'h0A; 0 appends nothing.
- `GAP_CYCLES`, 1000: idle cycles between messages in repeat mode, ≥1.
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: one-shot trigger; sampled only in IDLE.
- `repeat_en` in 1: level; when high, messages are sent continuously.
- `value` in 32: number to print; latched at message start.
- `tx_valid` out 1: `tx_data` is a byte to send.
- `tx_data` out 8: byte to `uart_tx`.
- `tx_ready` in 1: `uart_tx` accepts the byte this cycle when `tx_valid` is also high.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle pulse on acceptance of a message's last byte.
- `msg_count` out 16: count of completed messages; wraps from 16'hFFFF to 0.

## Operation
- Message length: L = MSG_LEN + HEX_DIGITS + 2*ADD_CRLF. Byte index `idx` runs 0..L-1.
- Byte map:
  - idx < MSG_LEN: text byte.
  - Next HEX_DIGITS indices: hex digits of the latched value, most significant nibble first, uppercase ASCII ('0'-'9' = 8'h30-8'h39, 'A'-'F' = 8'h41-8'h46).
  - Then CR, LF.
- States:
  - IDLE: `tx_valid`=0. If `start` or `repeat_en`, latch `value`, set idx=0, go to SEND.
  - SEND: `tx_valid`=1, `tx_data`=byte(idx).
    - On accept with idx<L-1: idx+1.
    - On accept with idx=L-1: pulse `done`, increment `msg_count`, then go to GAP if `repeat_en` is high in that cycle, else to IDLE.
  - GAP: `tx_valid`=0 for GAP_CYCLES cycles. When the gap expires:
    - if `repeat_en` is high, re-latch `value`, set idx=0, go to SEND;
    - otherwise go to IDLE.
- Handshake rules:
  - Once `tx_valid` rises, it stays high and `tx_data` stays stable until accepted. Only reset may withdraw it.
  - Bytes within one message are back-to-back: the next byte is presented the cycle after an accept, with `tx_valid` held high.
- `start` is ignored in SEND and GAP. If `start` and `repeat_en` are high together in IDLE, exactly one message starts.
- Dropping `repeat_en` mid-message does not abort it. The message completes, then the block returns to IDLE.
- `value` changes during a message do not affect that message.
- All outputs are registered.

## Timing
- Reset: state=IDLE, `tx_valid`=0, `tx_data`=8'h00, `busy`=0, `done`=0, `msg_count`=0, idx=0.
- Reset mid-message: `tx_valid` is 0 the cycle after `rst` is sampled. There is no resume; the next message starts from idx 0.
- Start latency: `start` sampled high at edge T, so `tx_valid`=1 with byte 0 and `busy`=1 from cycle T+1.
- With `tx_ready` held high, an L-byte message occupies exactly L consecutive valid cycles.
- `done` and the `msg_count` update appear in the cycle after the last accept. `tx_valid`=0 in that same cycle.
- Repeat: last accept in cycle A. `tx_valid` is low for cycles A+1..A+GAP_CYCLES, and byte 0 of the next message is valid at A+GAP_CYCLES+1.
- One-shot return: `busy` falls in the cycle after the last accept.

## Test plan
- Defaults, `tx_ready`=1, one `start` pulse: bytes 48 65 6C 6C 6F 0D 0A on 7 consecutive cycles starting 1 cycle after `start`; single `done` pulse; `msg_count`=1; `busy` then 0.
- Backpressure: `tx_ready` pattern 0,0,1,0,1,… : each byte holds stable with `tx_valid` high until accepted; no byte dropped or duplicated; `done` pulses once.
- HEX_DIGITS=4, `value`=32'h00001A2F, with `value` changed to 32'hFFFF after start: stream "Hello1A2F\r\n" (… 6F 31 41 32 46 0D 0A).
- `repeat_en`=1, GAP_CYCLES=10: exactly 10 cycles with `tx_valid` low between consecutive messages. Dropping `repeat_en` mid-message: that message completes, then IDLE, no further bytes.
- `start` re-pulsed during SEND and during GAP: ignored, and the byte stream is unchanged.
- `rst` asserted at byte 3: `tx_valid`=0 the next cycle and `msg_count`=0. A new `start` sends from 8'h48.
